// File: rtl/multicycle_alu_if.sv
// Handshake/operand/result bundle for multicycle_alu.
// master = register-read/writeback side, slave = the ALU.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [3:0]       fcode;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] ext_out;
    logic             cFlag;
    logic             zFlag;
    logic             sFlag;
    logic             oFlag;
    logic             illegal;

    modport master (
        output in_valid, opcode, fcode, inp1, inp2, out_ready,
        input  in_ready, out_valid, out, ext_out, cFlag, zFlag, sFlag, oFlag, illegal
    );

    modport slave (
        input  in_valid, opcode, fcode, inp1, inp2, out_ready,
        output in_ready, out_valid, out, ext_out, cFlag, zFlag, sFlag, oFlag, illegal
    );
endinterface

// File: rtl/multicycle_alu.sv
// Clocked ALU with valid/ready on both sides; single-cycle ops plus an optional
// iterative shift-add multiplier, built only when ALU_MUL_EN is defined.
//
// state | meaning
// IDLE  | accepts ops; single-cycle results register here
// MUL   | one shift-add step per cycle, counter counts WIDTH down to 0
// FIX   | restore product sign, register result and flags
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic             clk,
    input logic             rst,
    multicycle_alu_if.slave alu
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
`ifdef ALU_MUL_EN
    localparam logic [1:0] ST_MUL   = 2'b01;
    localparam logic [1:0] ST_FIX   = 2'b10;
    localparam int         CW       = $clog2(WIDTH) + 1;
`endif
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_IMM   = 3'b001;

    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] ext_q, ext_d;
    logic             c_q, c_d, z_q, z_d, s_q, s_d, o_q, o_d, ill_q, ill_d;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             is_add, res_bad, res_c, res_o;

`ifdef ALU_MUL_EN
    logic               mul_op, mul_sgn;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_fix;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH:0]     step_sum;
`endif

    assign alu.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || alu.out_ready);
    assign accept        = alu.in_valid && alu.in_ready;
    assign sum           = {1'b0, alu.inp1} + {1'b0, alu.inp2};
    assign shamt         = alu.inp2[SHW-1:0];
    assign res_c         = is_add && sum[WIDTH];
    assign res_o         = is_add && (alu.inp1[WIDTH-1] == alu.inp2[WIDTH-1])
                                  && (sum[WIDTH-1] != alu.inp1[WIDTH-1]);

    assign alu.out_valid = out_valid_q;
    assign alu.out       = out_q;
    assign alu.ext_out   = ext_q;
    assign alu.cFlag     = c_q;
    assign alu.zFlag     = z_q;
    assign alu.sFlag     = s_q;
    assign alu.oFlag     = o_q;
    assign alu.illegal   = ill_q;

    // Opcode/fcode decode; res stays 0 for unsupported codes.
    always_comb begin
        res     = '0;
        is_add  = 1'b0;
        res_bad = 1'b0;
`ifdef ALU_MUL_EN
        mul_op  = 1'b0;
        mul_sgn = 1'b0;
`endif
        case (alu.opcode)
            OP_RTYPE: begin
                case (alu.fcode)
                    4'b0000: res = alu.inp1 ^ alu.inp2;
                    4'b0001: res = alu.inp1 & alu.inp2;
                    4'b0010: res = '0 - alu.inp2;
                    4'b0011: begin
                        res    = sum[WIDTH-1:0];
                        is_add = 1'b1;
                    end
                    4'b0100, 4'b0110: res = alu.inp1 << shamt;
                    4'b0101, 4'b0111: res = alu.inp1 >> shamt;
                    4'b1000, 4'b1001: res = $signed(alu.inp1) >>> shamt;
                    4'b1010, 4'b1011: begin
`ifdef ALU_MUL_EN
                        mul_op  = 1'b1;
                        mul_sgn = alu.fcode[0];
`else
                        res_bad = 1'b1;
`endif
                    end
                    default: res_bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                case (alu.fcode)
                    4'b0000: begin
                        res    = sum[WIDTH-1:0];
                        is_add = 1'b1;
                    end
                    4'b0001: res = '0 - alu.inp2;
                    default: res_bad = 1'b1;
                endcase
            end
            default: res_bad = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_fix = (neg_q && (prod_q != '0)) ? ('0 - prod_q) : prod_q;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ext_d       = ext_q;
        c_d         = c_q;
        z_d         = z_q;
        s_d         = s_q;
        o_d         = o_q;
        ill_d       = ill_q;
`ifdef ALU_MUL_EN
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    // Signed multiply runs on magnitudes; the sign is restored in FIX.
                    if (mul_op) begin
                        mcand_d     = (mul_sgn && alu.inp1[WIDTH-1]) ? ('0 - alu.inp1) : alu.inp1;
                        prod_d      = {{WIDTH{1'b0}},
                                       (mul_sgn && alu.inp2[WIDTH-1]) ? ('0 - alu.inp2) : alu.inp2};
                        neg_d       = mul_sgn && (alu.inp1[WIDTH-1] ^ alu.inp2[WIDTH-1]);
                        cnt_d       = CW'(WIDTH);
                        out_valid_d = 1'b0;
                        state_d     = ST_MUL;
                    end else
`endif
                    begin
                        out_valid_d = 1'b1;
                        out_d       = res;
                        ext_d       = '0;
                        c_d         = res_c;
                        o_d         = res_o;
                        z_d         = !res_bad && (res == '0);
                        s_d         = res[WIDTH-1];
                        ill_d       = res_bad;
                    end
                end else if (out_valid_q && alu.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                prod_d = {step_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_d       = prod_fix[WIDTH-1:0];
                ext_d       = prod_fix[2*WIDTH-1:WIDTH];
                c_d         = 1'b0;
                o_d         = 1'b0;
                z_d         = (prod_fix == '0);
                s_d         = prod_fix[2*WIDTH-1];
                ill_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ext_q       <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            s_q         <= 1'b0;
            o_q         <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ext_q       <= ext_d;
            c_q         <= c_d;
            z_q         <= z_d;
            s_q         <= s_d;
            o_q         <= o_d;
            ill_q       <= ill_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against an arithmetic
// reference model; multiply checks are built when ALU_MUL_EN is defined.
module tb_multicycle_alu;

    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_alu_if #(.WIDTH(W)) bus ();

    multicycle_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .alu (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] o;
        logic [31:0] e;
        logic [3:0]  f;    // {c, z, s, o}
        logic        ill;
        logic        mul;
    } exp_t;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] opc, input logic [3:0] fc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t              r;
        logic [63:0]       us;
        logic [63:0]       p;
        logic signed [63:0] sa, sb;
        longint            t;
        bit                add;
        r   = '0;
        add = 1'b0;
        p   = '0;
        sa  = $signed(a);
        sb  = $signed(b);
        if (opc == 3'b000) begin
            case (fc)
                4'd0:       r.o = a ^ b;
                4'd1:       r.o = a & b;
                4'd2:       r.o = 32'd0 - b;
                4'd3:       add = 1'b1;
                4'd4, 4'd6: r.o = a << b[4:0];
                4'd5, 4'd7: r.o = a >> b[4:0];
                4'd8, 4'd9: r.o = $signed(a) >>> b[4:0];
                4'd10:      if (MUL_EN) begin r.mul = 1'b1; p = {32'd0, a} * {32'd0, b}; end else r.ill = 1'b1;
                4'd11:      if (MUL_EN) begin r.mul = 1'b1; p = sa * sb; end else r.ill = 1'b1;
                default:    r.ill = 1'b1;
            endcase
        end else if (opc == 3'b001) begin
            case (fc)
                4'd0:    add = 1'b1;
                4'd1:    r.o = 32'd0 - b;
                default: r.ill = 1'b1;
            endcase
        end else begin
            r.ill = 1'b1;
        end
        if (add) begin
            us     = {32'd0, a} + {32'd0, b};
            r.o    = us[31:0];
            t      = longint'(sa) + longint'(sb);
            r.f[3] = us[32];
            r.f[0] = (t != longint'($signed(r.o)));
        end
        if (r.mul) begin
            r.o    = p[31:0];
            r.e    = p[63:32];
            r.f[2] = (p == 64'd0);
            r.f[1] = p[63];
        end else if (!r.ill) begin
            r.f[2] = (r.o == 32'd0);
            r.f[1] = r.o[31];
        end
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [2:0] opc, input logic [3:0] fc,
                         input logic [31:0] a, input logic [31:0] b);
        bus.opcode = opc;
        bus.fcode  = fc;
        bus.inp1   = a;
        bus.inp2   = b;
    endtask

    task automatic check_result(input string tag, input exp_t e);
        check_val({tag, "_out"},   bus.out, e.o);
        check_val({tag, "_ext"},   bus.ext_out, e.e);
        check_val({tag, "_flags"}, {bus.cFlag, bus.zFlag, bus.sFlag, bus.oFlag}, e.f);
        check_val({tag, "_ill"},   bus.illegal, e.ill);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_valid"}, bus.out_valid, 0);
        check_result(tag, '0);
    endtask

    // lat counts edges from presentation including the accept edge:
    // single-cycle ops are visible right after it, multiplies W MUL + 1 FIX edges later.
    task automatic run_op(input string tag, input logic [2:0] opc, input logic [3:0] fc,
                          input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        int   guard;
        int   early;
        e             = model(opc, fc, a, b);
        bus.out_ready = 1'b1;
        guard         = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) check_val({tag, "_rdy_timeout"}, 0, 1);
        drive(opc, fc, a, b);
        bus.in_valid = 1'b1;
        lat   = 0;
        early = 0;
        do begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat++;
            if (!bus.out_valid && bus.in_ready) early++;
        end while (!bus.out_valid && lat < 100);
        check_val({tag, "_lat"}, lat, e.mul ? W + 2 : 1);
        if (e.mul) check_val({tag, "_busy_rdy"}, early, 0);
        check_result(tag, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  b2b_fc [3];
        logic [31:0] b2b_a  [3];
        logic [31:0] b2b_b  [3];
        exp_t        held;
        int          seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(3'b000, 4'b0000, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_zero("reset");
        check_val("reset_rdy", bus.in_ready, 1);

        run_op("add_ovf", 3'b000, 4'b0011, 32'h7FFF_FFFF, 32'h0000_0001);
        check_val("add_ovf_const", {bus.out, bus.cFlag, bus.zFlag, bus.sFlag, bus.oFlag},
                  {32'h8000_0000, 4'b0011});

        run_op("addi_carry", 3'b001, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
        check_val("addi_carry_const", {bus.out, bus.cFlag, bus.zFlag, bus.sFlag, bus.oFlag},
                  {32'h0000_0000, 4'b1100});

        run_op("shra", 3'b000, 4'b1000, 32'h8000_0000, 32'h0000_0024);
        check_val("shra_const", bus.out, 32'hF800_0000);

        run_op("ill_opc", 3'b010, 4'b0000, 32'h1234_5678, 32'h1);
        check_val("ill_opc_const", {bus.illegal, bus.out}, {1'b1, 32'h0});
        run_op("ill_fc", 3'b000, 4'b1111, 32'h1234_5678, 32'h1);
        check_val("ill_fc_const", {bus.illegal, bus.out}, {1'b1, 32'h0});
        run_op("legal_after_ill", 3'b000, 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00);

`ifdef ALU_MUL_EN
        run_op("smul", 3'b000, 4'b1011, 32'hFFFF_FFFD, 32'd5);
        check_val("smul_const", {bus.ext_out, bus.out, bus.sFlag},
                  {64'hFFFF_FFFF_FFFF_FFF1, 1'b1});
        run_op("umul", 3'b000, 4'b1010, 32'hFFFF_FFFF, 32'd2);
        check_val("umul_const", {bus.ext_out, bus.out}, {32'h1, 32'hFFFF_FFFE});
        run_op("smul_zero", 3'b000, 4'b1011, 32'hFFFF_FFF9, 32'd0);
        check_val("smul_zero_const", {bus.ext_out, bus.out, bus.sFlag, bus.zFlag},
                  {64'h0, 1'b0, 1'b1});
`else
        run_op("mul_off", 3'b000, 4'b1011, 32'hFFFF_FFFD, 32'd5);
        check_val("mul_off_const", {bus.illegal, bus.ext_out, bus.out}, {1'b1, 64'h0});
`endif

        // Back-to-back single-cycle ops, then writeback stall.
        b2b_fc = '{4'b0000, 4'b0001, 4'b0010};
        b2b_a  = '{32'hDEAD_BEEF, 32'h0F0F_FFFF, 32'h0};
        b2b_b  = '{32'h1234_5678, 32'hFFF0_00F0, 32'h0000_0001};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, b2b_fc[i], b2b_a[i], b2b_b[i]);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_val("b2b_valid", bus.out_valid, 1);
            check_result("b2b", model(3'b000, b2b_fc[i], b2b_a[i], b2b_b[i]));
        end
        held          = model(3'b000, b2b_fc[2], b2b_a[2], b2b_b[2]);
        bus.out_ready = 1'b0;
        drive(3'b000, 4'b0000, $urandom, $urandom);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_val("hold_rdy", bus.in_ready, 0);
            check_val("hold_valid", bus.out_valid, 1);
            check_result("hold", held);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("drain_valid", bus.out_valid, 0);

        // Reset in the middle of a multi-cycle op (or a plain result without the multiplier).
        bus.out_ready = 1'b1;
        drive(3'b000, MUL_EN ? 4'b1011 : 4'b0000, 32'hFFFF_FFF9, 32'd6);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check_val("rst_no_result", seen, 0);
        run_op("post_rst_add", 3'b000, 4'b0011, 32'h0000_0005, 32'h0000_0007);
        check_val("post_rst_add_const", bus.out, 32'd12);

        for (int n = 0; n < 150; n++) begin
            logic [2:0] opc;
            logic [3:0] fc;
            int         r;
            r = $urandom_range(0, 15);
            if (r < 12) begin
                opc = 3'b000;
                fc  = 4'($urandom_range(0, 15));
            end else if (r < 15) begin
                opc = 3'b001;
                fc  = 4'($urandom_range(0, 3));
            end else begin
                opc = 3'($urandom_range(2, 7));
                fc  = 4'($urandom_range(0, 15));
            end
            run_op("rand", opc, fc, pick(), pick());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
